// File: rtl/ht_pkg.sv
// ============================================================================
// Module   : ht_pkg
// Purpose  : Shared types and default sizing for the ht datapath scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ht_pkg;

  localparam int HT_NREQ  = 4;
  localparam int HT_LAT   = 4;
  // Tag field is sized generously; instances use the low IDX_W bits.
  localparam int HT_TAG_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ht_state_e;

  typedef struct packed {
    logic                valid;
    logic [HT_TAG_W-1:0] tag;
  } ht_entry_t;

endpackage

`default_nettype wire

// File: rtl/ht_sched_if.sv
// ============================================================================
// Module   : ht_sched_if
// Purpose  : Requester handshake and datapath issue/result signals.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ht_sched_if
  import ht_pkg::*;
#(
  parameter int NREQ  = HT_NREQ,
  parameter int IDX_W = $clog2(NREQ)
);

  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic             ht_start;
  logic [IDX_W-1:0] ht_sel;
  logic             res_valid;
  logic [IDX_W-1:0] res_tag;

  modport master (
    output req_valid,
    input  req_ready, ht_start, ht_sel, res_valid, res_tag
  );

  modport slave (
    input  req_valid,
    output req_ready, ht_start, ht_sel, res_valid, res_tag
  );

endinterface

`default_nettype wire

// File: rtl/ht_rr_arb.sv
// ============================================================================
// Module   : ht_rr_arb
// Purpose  : Round-robin one-hot arbiter; search begins at index ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ht_rr_arb #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  wire logic [NREQ-1:0]  req,
  input  wire logic [IDX_W-1:0] ptr,
  output logic      [NREQ-1:0]  gnt
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      // Wrap ptr+k into 0..NREQ-1 without relying on a power-of-two NREQ.
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NREQ)) begin
        sum = sum - (IDX_W+1)'(NREQ);
      end
      idx = sum[IDX_W-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ht_sched.sv
// ============================================================================
// Module   : ht_sched
// Purpose  : Round-robin job scheduler for a fixed-latency ht datapath.
//            Optional per-requester issue counters: HT_SCHED_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ht_sched
  import ht_pkg::*;
#(
  parameter int NREQ  = HT_NREQ,
  parameter int LAT   = HT_LAT,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic en,
  input  wire logic pipe_mode,
  ht_sched_if.slave bus,
  output logic      busy,
  output logic      over
`ifdef HT_SCHED_STATS_EN
  ,
  output logic [NREQ-1:0][15:0] stat_cnt
`endif
);

  localparam int CNT_W = $clog2(LAT+1);

  ht_state_e        state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ht_entry_t        pipe_q [LAT];
  ht_entry_t        pipe_d [LAT];

  logic [NREQ-1:0]  arb_gnt;
  logic [NREQ-1:0]  ready;
  logic [IDX_W-1:0] sel;
  logic             any_req;
  logic             cnt_free;
  logic             grant_ok;
  logic             issue;
  logic             done;

  ht_rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  // Grant, issue, tag pipeline and in-flight accounting.
  always_comb begin
    any_req  = |bus.req_valid;
    done     = pipe_q[LAT-1].valid && !rst;
    // In serial mode a slot frees up on the same cycle the last result leaves.
    cnt_free = (cnt_q == '0) || ((cnt_q == CNT_W'(1)) && done);
    // Every state may grant once en and a request are seen together.
    grant_ok = !rst && en && any_req && (pipe_mode || cnt_free);
    ready    = grant_ok ? arb_gnt : '0;
    issue    = |(bus.req_valid & ready);

    sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ready[i]) begin
        sel = IDX_W'(i);
      end
    end

    ptr_d = ptr_q;
    if (issue) begin
      ptr_d = (sel == IDX_W'(NREQ-1)) ? '0 : sel + IDX_W'(1);
    end

    pipe_d[0].valid = issue;
    pipe_d[0].tag   = HT_TAG_W'(sel);
    for (int i = 1; i < LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    cnt_d = cnt_q;
    if (issue && !done) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!issue && done) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (en && any_req) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_d == '0)          state_d = ST_IDLE;
        else if (!en || !any_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (en && any_req)        state_d = ST_RUN;
        else if (cnt_d == '0)     state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      pipe_q  <= pipe_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.ht_start  = issue;
  assign bus.ht_sel    = sel;
  assign bus.res_valid = done;
  assign bus.res_tag   = pipe_q[LAT-1].tag[IDX_W-1:0];
  assign busy          = (cnt_q != '0);
  assign over          = done && !issue && (cnt_q == CNT_W'(1));

`ifdef HT_SCHED_STATS_EN
  logic [NREQ-1:0][15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (issue && (stat_q[sel] != 16'hFFFF)) begin
      stat_d[sel] = stat_q[sel] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stat_q <= '0;
    else     stat_q <= stat_d;
  end

  assign stat_cnt = stat_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ht_sched.sv
// ============================================================================
// Module   : tb_ht_sched
// Purpose  : Directed self-checking bench for ht_sched (NREQ=4, LAT=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ht_sched;
  import ht_pkg::*;

  logic clk;
  logic rst;
  logic en;
  logic pipe_mode;
  logic busy;
  logic over;
`ifdef HT_SCHED_STATS_EN
  logic [3:0][15:0] stat_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int nres;
  int nover;

  ht_sched_if #(.NREQ(4), .IDX_W(2)) bus ();

  ht_sched #(.NREQ(4), .LAT(4), .IDX_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pipe_mode (pipe_mode),
    .bus       (bus.slave),
    .busy      (busy),
    .over      (over)
`ifdef HT_SCHED_STATS_EN
    ,
    .stat_cnt  (stat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; bus.req_valid = '0;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pipe_mode = 1'b1; bus.req_valid = '0;
    repeat (2) @(negedge clk);

    // rst overrides active requests
    en = 1'b1; bus.req_valid = 4'hF; #1;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_start", bus.ht_start, 0);
    @(negedge clk); rst = 1'b0; en = 1'b0; bus.req_valid = '0; #1;
    chk("rst_state", dut.state_q, ST_IDLE);
    chk("rst_ptr", dut.ptr_q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resv", bus.res_valid, 0);
    chk("rst_over", over, 0);

    // en low blocks grants
    @(negedge clk); bus.req_valid = 4'hF; #1;
    chk("enlow_ready", bus.req_ready, 0);

    // single job on requester 2
    @(negedge clk); en = 1'b1; pipe_mode = 1'b1; bus.req_valid = 4'b0100; #1;
    chk("one_start", bus.ht_start, 1);
    chk("one_sel", bus.ht_sel, 2);
    chk("one_ready", bus.req_ready, 4'b0100);
    @(negedge clk); bus.req_valid = '0; #1;
    chk("one_busy", busy, 1);
    chk("one_run", dut.state_q, ST_RUN);
    @(negedge clk); #1;
    chk("one_drain", dut.state_q, ST_DRAIN);
    @(negedge clk); #1;
    chk("one_early", bus.res_valid, 0);
    @(negedge clk); #1;
    chk("one_resv", bus.res_valid, 1);
    chk("one_tag", bus.res_tag, 2);
    chk("one_over", over, 1);
    @(negedge clk); #1;
    chk("one_resv_off", bus.res_valid, 0);
    chk("one_idle_busy", busy, 0);
    chk("one_idle", dut.state_q, ST_IDLE);
    chk("one_ptr", dut.ptr_q, 3);

    // fairness: all four requesting, back-to-back
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); bus.req_valid = 4'hF; #1;
      chk("fair_start", bus.ht_start, 1);
      chk("fair_sel", bus.ht_sel, k % 4);
      chk("fair_resv", bus.res_valid, (k >= 4) ? 1 : 0);
      if (k >= 4) chk("fair_tag", bus.res_tag, k % 4);
    end
    for (int k = 8; k < 12; k++) begin
      @(negedge clk); bus.req_valid = '0; #1;
      chk("fair_tail_resv", bus.res_valid, 1);
      chk("fair_tail_tag", bus.res_tag, k % 4);
      chk("fair_tail_over", over, (k == 11) ? 1 : 0);
    end
    @(negedge clk); #1;
    chk("fair_busy", busy, 0);
    chk("fair_idle", dut.state_q, ST_IDLE);

    // serial mode: one job in flight at a time
    do_reset();
    pipe_mode = 1'b0;
    @(negedge clk); bus.req_valid = 4'b0011; #1;
    chk("ser_start0", bus.ht_start, 1);
    chk("ser_sel0", bus.ht_sel, 0);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); #1;
      chk("ser_hold", bus.req_ready, 0);
      if (k == 2) chk("ser_run", dut.state_q, ST_RUN);
    end
    @(negedge clk); #1;
    chk("ser_resv0", bus.res_valid, 1);
    chk("ser_tag0", bus.res_tag, 0);
    chk("ser_start1", bus.ht_start, 1);
    chk("ser_sel1", bus.ht_sel, 1);
    chk("ser_noover", over, 0);
    @(negedge clk); bus.req_valid = '0;
    repeat (2) @(negedge clk);
    @(negedge clk); #1;
    chk("ser_resv1", bus.res_valid, 1);
    chk("ser_tag1", bus.res_tag, 1);
    chk("ser_over", over, 1);
    @(negedge clk); #1;
    chk("ser_idle", dut.state_q, ST_IDLE);

    // drain: three jobs then en drops
    do_reset();
    pipe_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); bus.req_valid = 4'b0111; #1;
      chk("drn_sel", bus.ht_sel, k);
    end
    nres = 0; nover = 0;
    @(negedge clk); en = 1'b0; #1;
    chk("drn_ready", bus.req_ready, 0);
    nres += int'(bus.res_valid); nover += int'(over);
    for (int k = 4; k <= 9; k++) begin
      @(negedge clk); #1;
      nres += int'(bus.res_valid); nover += int'(over);
      if (k == 4) chk("drn_state", dut.state_q, ST_DRAIN);
      if (k == 5) chk("drn_ready2", bus.req_ready, 0);
    end
    chk("drn_nres", nres, 3);
    chk("drn_nover", nover, 1);
    chk("drn_idle", dut.state_q, ST_IDLE);
    chk("drn_busy", busy, 0);

    // reset two cycles after an issue discards the job
    en = 1'b1;
    do_reset();
    @(negedge clk); bus.req_valid = 4'b0001; #1;
    chk("rmf_start", bus.ht_start, 1);
    @(negedge clk); bus.req_valid = '0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("rmf_busy", busy, 0);
    chk("rmf_ptr", dut.ptr_q, 0);
    chk("rmf_state", dut.state_q, ST_IDLE);
    nres = int'(bus.res_valid);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      nres += int'(bus.res_valid);
    end
    chk("rmf_nres", nres, 0);

`ifdef HT_SCHED_STATS_EN
    // saturating issue counter
    do_reset();
    en = 1'b1; pipe_mode = 1'b1;
    @(negedge clk); bus.req_valid = 4'b0010;
    repeat (70000) @(negedge clk);
    #1;
    chk("stat_sat1", stat_cnt[1], 16'hFFFF);
    chk("stat_zero0", stat_cnt[0], 16'h0000);
    bus.req_valid = '0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ht_sched.md
HT_SCHED -- requirements
Module: ht_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the ht datapath.
REQ-002 Parameter LAT, default 4, cycles from ht_start asserted to ht outdata valid.
REQ-003 Parameter IDX_W, default 2, requester index width, equal to clog2(NREQ).
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  scheduler enable; low blocks new grants.
REQ-007 pipe_mode  input  1  1 = back-to-back issue; 0 = at most one job in flight.
REQ-008 req_valid  input  NREQ  per-requester job request.
REQ-009 req_ready  output  NREQ  one-hot grant; a job transfers when req_valid[i] and req_ready[i] are both high.
REQ-010 ht_start  output  1  issue strobe to the datapath start port.
REQ-011 ht_sel  output  IDX_W  granted index, driving the external indata mux; valid only while ht_start is high.
REQ-012 res_valid  output  1  one-cycle strobe marking ht outdata valid.
REQ-013 res_tag  output  IDX_W  requester index owning the current result.
REQ-014 busy  output  1  high while any job is in flight.
REQ-015 over  output  1  one-cycle pulse when the in-flight count reaches zero.

Function
REQ-016 FSM states: IDLE, RUN, DRAIN.
REQ-017 Transitions: IDLE->RUN when en and any req_valid; RUN->DRAIN when en is low or no req_valid while jobs are in flight; RUN->IDLE when no job is in flight and no grant is made; DRAIN->RUN when en and any req_valid; DRAIN->IDLE when the last in-flight job completes.
REQ-018 Grant is allowed only in RUN, or in IDLE/DRAIN on the cycle en and req_valid are seen; with pipe_mode=0 it additionally requires an in-flight count of 0.
REQ-019 Arbitration is round-robin: search starts at pointer ptr; after a grant to index g, ptr becomes (g+1) mod NREQ; ptr is unchanged when nothing is granted.
REQ-020 req_ready is combinational from req_valid and registered state; at most one bit is high; ht_start equals OR(req_valid & req_ready).
REQ-021 Issued tags travel through an LAT-deep valid/tag shift register; res_valid/res_tag appear exactly LAT cycles after the matching ht_start, in issue order.
REQ-022 In-flight counter width is clog2(LAT+1); it increments on issue and decrements on res_valid; on simultaneous issue and completion it holds.
REQ-023 over pulses on the cycle in which the counter goes from 1 to 0 with no simultaneous issue.
REQ-024 Dropping en mid-operation never cancels in-flight jobs; all of them complete.
REQ-025 Changing pipe_mode takes effect on the next grant decision; jobs already in flight are unaffected.

Reset
REQ-026 rst overrides all other inputs; in the following cycle: state IDLE, ptr 0, shift register empty, counter 0, all outputs 0.
REQ-027 rst asserted mid-operation discards every in-flight tag; no res_valid is produced for those jobs.

Configuration
REQ-028 HT_SCHED_STATS_EN defined: adds output stat_cnt (NREQ x 16) holding per-requester issue counts, incrementing saturatingly at 16'hFFFF and cleared by rst.
REQ-029 HT_SCHED_STATS_EN undefined: no stat_cnt port and no counter logic; all other behaviour is identical.

Structure
REQ-030 Package ht_pkg holds the FSM state enum, default NREQ/LAT constants, and the tag pipeline entry struct (valid, tag).
REQ-031 Round-robin arbitration lives in sub-module ht_rr_arb (inputs req and ptr; output one-hot grant); everything else stays in ht_sched.

Verification
REQ-032 Single job: en=1, pipe_mode=1, req_valid=4'b0100 for one cycle -> ht_start with ht_sel=2; res_valid with res_tag=2 four cycles later; over on that same cycle.
REQ-033 Fairness: all four req_valid held high for 8 cycles -> grants 0,1,2,3,0,1,2,3; one ht_start per cycle.
REQ-034 Serial mode: pipe_mode=0, req_valid=4'b0011 held -> grant 0, no grant for 3 cycles, then grant 1 on the cycle res_valid for tag 0 fires.
REQ-035 Drain: 3 jobs issued, then en=0 -> FSM in DRAIN, no further req_ready, 3 res_valid strobes, over pulses once, FSM in IDLE.
REQ-036 Reset mid-flight: rst asserted 2 cycles after an issue -> no res_valid ever appears; busy=0 and ptr=0 on the cycle after rst.
REQ-037 Stats (macro on): 70000 grants to requester 1 -> stat_cnt[1] = 16'hFFFF.
